l1_mmu_arbiter: RTL and testbench

- Arbitrates the single shared l1mmu refill/writeback port between the L1 instruction cache (read-only line fills) and the L1 data cache (line fills and line writebacks).
- Sits between the two L1 caches and l1mmu.
- Captures the winning request into registers, holds it on the MMU port until the matching done, and routes done/data back to the owner only.

---
 rtl/l1_arb_pkg.sv | 26 ++
 rtl/arb_rr_pick2.sv | 19 +
 rtl/l1_mmu_arbiter.sv | 167 ++++++++++++++++
 tb/tb_l1_mmu_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_arb_pkg.sv
// Shared types and constants for the L1 refill/writeback arbiter: FSM state
// encoding, grant-owner codes and default bus widths.
package l1_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_LINE_W = 256;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IC_BUSY = 2'd1,
      DC_BUSY = 2'd2
   } arb_state_e;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_IC   = 2'b01;
   localparam logic [1:0] OWN_DC   = 2'b10;

   function automatic logic [1:0] ownerOf(input arb_state_e s);
      case (s)
         IC_BUSY: return OWN_IC;
         DC_BUSY: return OWN_DC;
         default: return OWN_NONE;
      endcase
   endfunction

endpackage

// File: rtl/arb_rr_pick2.sv
// Two-way request picker. req[0] is the instruction cache, req[1] the data
// cache; last_grant = 1 means the data cache won the previous grant.
module arb_rr_pick2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       fixed_prio,
   output logic [1:0] grant
);

   // A lone requester always wins; a conflict goes to the IC when priority
   // is fixed, otherwise to whoever did not win last time.
   always_comb begin
      grant = req;
      if (&req) begin
         grant = (fixed_prio || last_grant) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/l1_mmu_arbiter.sv
// Arbiter sharing one l1mmu refill/writeback port between the L1 I-cache and
// D-cache. Optional performance counters are enabled with L1_MMU_ARB_PERF_EN.
module l1_mmu_arbiter
   import l1_arb_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int LINE_W      = DEF_LINE_W,
   parameter int LINE_OFFSET = 5,
   parameter int FIXED_PRIO  = 0
) (
   input  logic              sys_clk,
   input  logic              rst,
`ifdef L1_MMU_ARB_PERF_EN
   input  logic              perf_clr,
   output logic [31:0]       ic_grant_cnt,
   output logic [31:0]       dc_grant_cnt,
   output logic [31:0]       conflict_cnt,
`endif
   input  logic              ic_req_read,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_read_done,
   output logic [LINE_W-1:0] ic_read_data,
   input  logic              dc_req_read,
   input  logic              dc_req_write,
   input  logic [ADDR_W-1:0] dc_req_addr,
   input  logic [LINE_W-1:0] dc_write_data,
   output logic              dc_read_done,
   output logic              dc_write_done,
   output logic [LINE_W-1:0] dc_read_data,
   output logic              mmu_req_read,
   output logic              mmu_req_write,
   output logic [ADDR_W-1:0] mmu_req_addr,
   output logic [LINE_W-1:0] mmu_write_data,
   input  logic              mmu_read_done,
   input  logic              mmu_write_done,
   input  logic [LINE_W-1:0] mmu_read_data,
   output logic              busy,
   output logic [1:0]        grant_owner
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK =
      ~((ADDR_W'(1) << LINE_OFFSET) - ADDR_W'(1));

   arb_state_e        state_q;
   logic              lastGrantDc_q;
   logic              mmuRead_q;
   logic              mmuWrite_q;
   logic [ADDR_W-1:0] mmuAddr_q;
   logic [LINE_W-1:0] mmuData_q;

   logic       dcReq;
   logic [1:0] grant;
   logic       icDone;
   logic       dcRdDone;
   logic       dcWrDone;

   assign dcReq = dc_req_read | dc_req_write;

   arb_rr_pick2 uPick (
      .req        ({dcReq, ic_req_read}),
      .last_grant (lastGrantDc_q),
      .fixed_prio (FIXED_PRIO != 0),
      .grant      (grant)
   );

   // Only a done that matches the owner and the captured type is forwarded.
   assign icDone   = (state_q == IC_BUSY) && mmu_read_done;
   assign dcRdDone = (state_q == DC_BUSY) && mmuRead_q  && mmu_read_done;
   assign dcWrDone = (state_q == DC_BUSY) && mmuWrite_q && mmu_write_done;

   // Grants capture the request into the MMU registers; completion clears them
   // and always passes through IDLE, giving the port one quiet cycle.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         lastGrantDc_q <= 1'b1;
         mmuRead_q     <= 1'b0;
         mmuWrite_q    <= 1'b0;
         mmuAddr_q     <= '0;
         mmuData_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant[0]) begin
                  state_q       <= IC_BUSY;
                  lastGrantDc_q <= 1'b0;
                  mmuRead_q     <= 1'b1;
                  mmuWrite_q    <= 1'b0;
                  mmuAddr_q     <= ic_req_addr & ALIGN_MASK;
                  mmuData_q     <= '0;
               end else if (grant[1]) begin
                  state_q       <= DC_BUSY;
                  lastGrantDc_q <= 1'b1;
                  mmuRead_q     <= ~dc_req_write;
                  mmuWrite_q    <= dc_req_write;
                  mmuAddr_q     <= dc_req_addr & ALIGN_MASK;
                  mmuData_q     <= dc_write_data;
               end
            end
            IC_BUSY, DC_BUSY: begin
               if (icDone || dcRdDone || dcWrDone) begin
                  state_q    <= IDLE;
                  mmuRead_q  <= 1'b0;
                  mmuWrite_q <= 1'b0;
                  mmuAddr_q  <= '0;
                  mmuData_q  <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mmu_req_read   = mmuRead_q;
   assign mmu_req_write  = mmuWrite_q;
   assign mmu_req_addr   = mmuAddr_q;
   assign mmu_write_data = mmuData_q;
   assign busy           = (state_q != IDLE);
   assign grant_owner    = ownerOf(state_q);
   assign ic_read_done   = icDone;
   assign ic_read_data   = icDone ? mmu_read_data : '0;
   assign dc_read_done   = dcRdDone;
   assign dc_write_done  = dcWrDone;
   assign dc_read_data   = dcRdDone ? mmu_read_data : '0;

`ifdef L1_MMU_ARB_PERF_EN
   logic [31:0] icCnt_q, icCnt_d;
   logic [31:0] dcCnt_q, dcCnt_d;
   logic [31:0] confCnt_q, confCnt_d;
   logic        inIdle;

   assign inIdle = (state_q == IDLE);

   // Saturating counters; a clear request overrides any same-cycle increment.
   always_comb begin
      icCnt_d   = icCnt_q;
      dcCnt_d   = dcCnt_q;
      confCnt_d = confCnt_q;
      if (perf_clr) begin
         icCnt_d   = '0;
         dcCnt_d   = '0;
         confCnt_d = '0;
      end else if (inIdle) begin
         if (grant[0] && (icCnt_q != '1)) icCnt_d = icCnt_q + 32'd1;
         if (grant[1] && (dcCnt_q != '1)) dcCnt_d = dcCnt_q + 32'd1;
         if (ic_req_read && dcReq && (confCnt_q != '1)) confCnt_d = confCnt_q + 32'd1;
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         icCnt_q   <= '0;
         dcCnt_q   <= '0;
         confCnt_q <= '0;
      end else begin
         icCnt_q   <= icCnt_d;
         dcCnt_q   <= dcCnt_d;
         confCnt_q <= confCnt_d;
      end
   end

   assign ic_grant_cnt = icCnt_q;
   assign dc_grant_cnt = dcCnt_q;
   assign conflict_cnt = confCnt_q;
`endif

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
// Scoreboard bench for l1_mmu_arbiter: a transaction-level model predicts grant
// order, captured requests and forwarded completions; a monitor checks them.
module tb_l1_mmu_arbiter;

   localparam int ADDR_W      = 32;
   localparam int LINE_W      = 256;
   localparam int LINE_OFFSET = 5;
   localparam int FIXED_PRIO  = 0;

   logic              sys_clk;
   logic              rst;
   logic              ic_req_read;
   logic [ADDR_W-1:0] ic_req_addr;
   logic              ic_read_done;
   logic [LINE_W-1:0] ic_read_data;
   logic              dc_req_read;
   logic              dc_req_write;
   logic [ADDR_W-1:0] dc_req_addr;
   logic [LINE_W-1:0] dc_write_data;
   logic              dc_read_done;
   logic              dc_write_done;
   logic [LINE_W-1:0] dc_read_data;
   logic              mmu_req_read;
   logic              mmu_req_write;
   logic [ADDR_W-1:0] mmu_req_addr;
   logic [LINE_W-1:0] mmu_write_data;
   logic              mmu_read_done;
   logic              mmu_write_done;
   logic [LINE_W-1:0] mmu_read_data;
   logic              busy;
   logic [1:0]        grant_owner;
`ifdef L1_MMU_ARB_PERF_EN
   logic              perf_clr;
   logic [31:0]       ic_grant_cnt;
   logic [31:0]       dc_grant_cnt;
   logic [31:0]       conflict_cnt;
`endif

   typedef struct {
      logic [1:0]        owner;
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
   } reqExp_t;

   typedef struct {
      logic              icRd;
      logic              dcRd;
      logic              dcWr;
      logic [LINE_W-1:0] data;
   } doneExp_t;

   reqExp_t  reqQ[$];
   doneExp_t doneQ[$];
   reqExp_t  curReq;
   logic     haveCur;
   logic     prevBusy;

   int vectors;
   int miscompares;

   // Reference-model state: who won the last grant, and event tallies.
   bit modelLastDc;
   int mIcGrants;
   int mDcGrants;
   int mConflicts;

   l1_mmu_arbiter #(
      .ADDR_W      (ADDR_W),
      .LINE_W      (LINE_W),
      .LINE_OFFSET (LINE_OFFSET),
      .FIXED_PRIO  (FIXED_PRIO)
   ) dut (
      .sys_clk        (sys_clk),
      .rst            (rst),
`ifdef L1_MMU_ARB_PERF_EN
      .perf_clr       (perf_clr),
      .ic_grant_cnt   (ic_grant_cnt),
      .dc_grant_cnt   (dc_grant_cnt),
      .conflict_cnt   (conflict_cnt),
`endif
      .ic_req_read    (ic_req_read),
      .ic_req_addr    (ic_req_addr),
      .ic_read_done   (ic_read_done),
      .ic_read_data   (ic_read_data),
      .dc_req_read    (dc_req_read),
      .dc_req_write   (dc_req_write),
      .dc_req_addr    (dc_req_addr),
      .dc_write_data  (dc_write_data),
      .dc_read_done   (dc_read_done),
      .dc_write_done  (dc_write_done),
      .dc_read_data   (dc_read_data),
      .mmu_req_read   (mmu_req_read),
      .mmu_req_write  (mmu_req_write),
      .mmu_req_addr   (mmu_req_addr),
      .mmu_write_data (mmu_write_data),
      .mmu_read_done  (mmu_read_done),
      .mmu_write_done (mmu_write_done),
      .mmu_read_data  (mmu_read_data),
      .busy           (busy),
      .grant_owner    (grant_owner)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   function automatic logic [LINE_W-1:0] randLine();
      logic [LINE_W-1:0] v;
      for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [ADDR_W-1:0] lineAlign(input logic [ADDR_W-1:0] a);
      return (a / (1 << LINE_OFFSET)) * (1 << LINE_OFFSET);
   endfunction

   task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                              input logic [LINE_W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops an expected request when a grant appears, holds it stable
   // for the whole transaction, and pops an expected completion on any done.
   always @(negedge sys_clk) begin
      if (rst) begin
         prevBusy = 1'b0;
         haveCur  = 1'b0;
      end else begin
         if (busy && !prevBusy) begin
            if (reqQ.size() == 0) begin
               checkOutput("unexpected_grant", 1'b1, 1'b0);
               haveCur = 1'b0;
            end else begin
               curReq  = reqQ.pop_front();
               haveCur = 1'b1;
            end
         end
         if (busy && haveCur) begin
            checkOutput("grant_owner", grant_owner, curReq.owner);
            checkOutput("mmu_req_read", mmu_req_read, curReq.rd);
            checkOutput("mmu_req_write", mmu_req_write, curReq.wr);
            checkOutput("mmu_req_addr", mmu_req_addr, curReq.addr);
            if (curReq.wr) checkOutput("mmu_write_data", mmu_write_data, curReq.wdata);
         end
         if (!busy) begin
            checkOutput("idle_port", {mmu_req_read, mmu_req_write, grant_owner}, 4'b0000);
         end
         if (ic_read_done || dc_read_done || dc_write_done) begin
            if (doneQ.size() == 0) begin
               checkOutput("unexpected_done", {ic_read_done, dc_read_done, dc_write_done}, 3'b000);
            end else begin
               doneExp_t d;
               d = doneQ.pop_front();
               checkOutput("done_flags", {ic_read_done, dc_read_done, dc_write_done},
                           {d.icRd, d.dcRd, d.dcWr});
               checkOutput("ic_read_data", ic_read_data, d.icRd ? d.data : '0);
               checkOutput("dc_read_data", dc_read_data, d.dcRd ? d.data : '0);
            end
         end else begin
            checkOutput("data_zero_no_done", {ic_read_data, dc_read_data}, '0);
         end
         prevBusy = busy;
      end
   end

   // Serves one granted transaction: waits for the grant, injects mismatched
   // done pulses that must be ignored, then completes it and drops the request.
   task automatic serveOne(input bit isIc, input int dcKind,
                           input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata);
      reqExp_t  r;
      doneExp_t d;
      int       n;
      bit       isWr;
      isWr    = !isIc && (dcKind != 0);
      r.owner = isIc ? 2'b01 : 2'b10;
      r.rd    = !isWr;
      r.wr    = isWr;
      r.addr  = lineAlign(addr);
      r.wdata = wdata;
      reqQ.push_back(r);
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!busy && n < 8);
      checkOutput("grant_latency", n, 2);
      if (!busy) begin
         reqQ.delete();
         ic_req_read  = 1'b0;
         dc_req_read  = 1'b0;
         dc_req_write = 1'b0;
         return;
      end
      @(posedge sys_clk);
      #1;
      repeat ($urandom_range(0, 2)) begin
         mmu_read_data = randLine();
         if (isWr) mmu_read_done = 1'b1;
         else      mmu_write_done = 1'b1;
         @(posedge sys_clk);
         #1;
         mmu_read_done  = 1'b0;
         mmu_write_done = 1'b0;
      end
      d.icRd = isIc;
      d.dcRd = !isIc && !isWr;
      d.dcWr = isWr;
      d.data = randLine();
      doneQ.push_back(d);
      mmu_read_data = d.data;
      if (isWr) mmu_write_done = 1'b1;
      else      mmu_read_done = 1'b1;
      @(posedge sys_clk);
      #1;
      mmu_read_done  = 1'b0;
      mmu_write_done = 1'b0;
      if (isIc) begin
         ic_req_read = 1'b0;
      end else begin
         dc_req_read  = 1'b0;
         dc_req_write = 1'b0;
      end
      checkOutput("idle_after_done", {busy, mmu_req_read, mmu_req_write}, 3'b000);
   endtask

   // One arbitration round: raise the chosen requests together and serve them
   // in the order the model predicts. dcKind: 0 read, 1 write, 2 read+write.
   task automatic applyStimulus(input bit reqIc, input bit reqDc, input int dcKind,
                                input logic [ADDR_W-1:0] icAddr,
                                input logic [ADDR_W-1:0] dcAddr);
      logic [LINE_W-1:0] wdata;
      bit                icFirst;
      wdata = randLine();
      @(posedge sys_clk);
      #1;
      ic_req_read   = reqIc;
      ic_req_addr   = icAddr;
      dc_req_read   = reqDc && (dcKind != 1);
      dc_req_write  = reqDc && (dcKind != 0);
      dc_req_addr   = dcAddr;
      dc_write_data = wdata;
      if (reqIc && reqDc) begin
         mConflicts++;
         icFirst = (FIXED_PRIO != 0) || modelLastDc;
      end else begin
         icFirst = reqIc;
      end
      for (int k = 0; k < 2; k++) begin
         bit serveIc;
         serveIc = (k == 0) ? icFirst : !icFirst;
         if ((serveIc && reqIc) || (!serveIc && reqDc)) begin
            modelLastDc = !serveIc;
            if (serveIc) mIcGrants++;
            else         mDcGrants++;
            serveOne(serveIc, dcKind, serveIc ? icAddr : dcAddr, wdata);
         end
      end
   endtask

   task automatic idleStray();
      @(posedge sys_clk);
      #1;
      mmu_read_done  = 1'($urandom_range(0, 1));
      mmu_write_done = 1'($urandom_range(0, 1));
      mmu_read_data  = randLine();
      @(posedge sys_clk);
      #1;
      mmu_read_done  = 1'b0;
      mmu_write_done = 1'b0;
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      prevBusy      = 1'b0;
      haveCur       = 1'b0;
      modelLastDc   = 1'b1;
      mIcGrants     = 0;
      mDcGrants     = 0;
      mConflicts    = 0;
      rst           = 1'b1;
      ic_req_read   = 1'b0;
      ic_req_addr   = '0;
      dc_req_read   = 1'b0;
      dc_req_write  = 1'b0;
      dc_req_addr   = '0;
      dc_write_data = '0;
      mmu_read_done = 1'b0;
      mmu_write_done = 1'b0;
      mmu_read_data = '0;
`ifdef L1_MMU_ARB_PERF_EN
      perf_clr      = 1'b0;
`endif
      #12;
      checkOutput("reset_state",
                  {busy, grant_owner, mmu_req_read, mmu_req_write, ic_read_done,
                   dc_read_done, dc_write_done},
                  '0);
      checkOutput("reset_addr", mmu_req_addr, '0);
      @(posedge sys_clk);
      #1;
      rst = 1'b0;

      applyStimulus(1'b1, 1'b0, 0, 32'h0000_1234, 32'h0);
      applyStimulus(1'b1, 1'b1, 0, 32'h0000_2000, 32'h0000_3010);
      applyStimulus(1'b1, 1'b1, 0, 32'h0000_4044, 32'h0000_5088);
      applyStimulus(1'b0, 1'b1, 1, 32'h0, 32'h8000_0040);
      applyStimulus(1'b0, 1'b1, 2, 32'h0, 32'h1234_567F);
      idleStray();
      for (int i = 0; i < 30; i++) begin
         int sel;
         int r;
         sel = $urandom_range(0, 2);
         r   = $urandom_range(0, 9);
         applyStimulus(sel != 1, sel != 0, (r < 5) ? 0 : ((r < 9) ? 1 : 2),
                       $urandom, $urandom);
         if ($urandom_range(0, 3) == 0) idleStray();
      end

`ifdef L1_MMU_ARB_PERF_EN
      checkOutput("ic_grant_cnt", ic_grant_cnt, mIcGrants);
      checkOutput("dc_grant_cnt", dc_grant_cnt, mDcGrants);
      checkOutput("conflict_cnt", conflict_cnt, mConflicts);
      @(posedge sys_clk);
      #1;
      perf_clr = 1'b1;
      @(posedge sys_clk);
      #1;
      perf_clr = 1'b0;
      checkOutput("perf_clr", {ic_grant_cnt, dc_grant_cnt, conflict_cnt}, '0);
`endif

      // Reset in the middle of a DC writeback, away from any clock edge.
      @(posedge sys_clk);
      #1;
      dc_req_write  = 1'b1;
      dc_req_addr   = 32'hCAFE_0123;
      dc_write_data = randLine();
      reqQ.push_back('{owner: 2'b10, rd: 1'b0, wr: 1'b1,
                       addr: lineAlign(32'hCAFE_0123), wdata: dc_write_data});
      @(negedge sys_clk);
      @(negedge sys_clk);
      checkOutput("busy_before_reset", busy, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_reset_outputs",
                  {busy, grant_owner, mmu_req_read, mmu_req_write}, '0);
      dc_req_write = 1'b0;
      reqQ.delete();
      doneQ.delete();
      modelLastDc = 1'b1;
      @(posedge sys_clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 0, 32'h0000_0FFF, 32'h0);
      applyStimulus(1'b1, 1'b1, 1, 32'h0000_1100, 32'h0000_2200);

      repeat (3) @(posedge sys_clk);
      checkOutput("scoreboard_drained", {reqQ.size(), doneQ.size()}, '0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
